seven_segment_scanner: RTL and testbench

- Time-multiplexed driver for a common-anode or common-cathode multi-digit seven-segment display.
- Captures a packed hex value, decodes one nibble per scan slot and drives the shared segment lines.
- Drives a one-hot digit-enable vector and per-digit decimal points.
- Successor to the single-digit combinational decoder; sits between the system value registers and the display pins.

---
 rtl/seven_seg_pkg.sv | 24 ++
 rtl/seven_seg_prescaler.sv | 36 +++
 rtl/seven_segment_scanner.sv | 134 +++++++++++++
 tb/tb_seven_segment_scanner.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared types and constants for the seven-segment scanner.
//   SEG_W      : number of segment lines (a..g).
//   seg_t      : segment vector {a,b,c,d,e,f,g}, a in the MSB.
//   SEG_TABLE  : active-high segment pattern for hex digits 0..F.
//   hex_to_seg : nibble -> segment pattern lookup.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// seven_seg_prescaler
//   Slot timer for the display scanner. Counts 0..REFRESH_DIV-1 and wraps.
//   Ports:
//     clk        : system clock, rising edge.
//     rst        : synchronous active-high reset (count -> 0).
//     slot_tick  : high while the count is at its terminal value; the
//                  digit index advances on the edge that ends this cycle.
//     slot_start : high while the count is 0 (first clock of a slot).
module seven_seg_prescaler #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic slot_tick,
  output logic slot_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign slot_tick  = (count_q == LAST);
  assign slot_start = (count_q == '0);

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed driver for a multi-digit seven-segment display.
//   A shadow copy of value/dots is captured on load; one digit is shown
//   per slot of REFRESH_DIV clocks, with digit_en held off for the first
//   clock of every slot to avoid ghosting between digits.
//   Ports:
//     clk, rst  : clock and synchronous active-high reset.
//     value     : packed hex digits, nibble i -> digit i (digit 0 rightmost).
//     dots      : decimal-point request per digit.
//     load      : capture strobe for value and dots.
//     blank     : forces the display dark while scanning continues.
//     seg       : segments {a..g}, a in the MSB.
//     dot       : decimal point of the active digit.
//     digit_en  : one-hot enable of the active digit.
//   Pins are inverted when ACTIVE_LOW=1; internal logic is active-high.
//   Optional macro SEVEN_SEG_LZB_EN enables leading-zero blanking.
//
//   Valid/ready: there is no handshake; load is a single-cycle strobe that
//   is always accepted on the edge where it is high.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic                    load,
  input  logic                    blank,
  output logic [SEG_W-1:0]        seg,
  output logic                    dot,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                       slot_tick;
  logic                       slot_start;
  logic [IDX_W-1:0]           idx_q;
  logic [NUM_DIGITS-1:0][3:0] shadow_value_q;
  logic [NUM_DIGITS-1:0]      shadow_dots_q;

  seg_t                       seg_d, seg_q;
  logic                       dot_d, dot_q;
  logic [NUM_DIGITS-1:0]      en_d, en_q;
  logic                       digit_dark;

  seven_seg_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .slot_tick  (slot_tick),
    .slot_start (slot_start)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_value_q <= '0;
      shadow_dots_q  <= '0;
    end else if (load) begin
      shadow_value_q <= value;
      shadow_dots_q  <= dots;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (slot_tick) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // lz_blank[i] is set when digit i and every more significant digit are
  // zero; digit 0 is always displayed.
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  tail_zero;

  always_comb begin
    lz_blank  = '0;
    tail_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      tail_zero   = tail_zero & (shadow_value_q[i] == 4'h0);
      lz_blank[i] = tail_zero;
    end
  end

  assign digit_dark = lz_blank[idx_q];
`else
  assign digit_dark = 1'b0;
`endif

  // Next output state is computed from the pre-edge index and shadow, so a
  // load or slot advance reaches the pins one clock later.
  always_comb begin
    seg_d = hex_to_seg(shadow_value_q[idx_q]);
    dot_d = shadow_dots_q[idx_q];
    en_d  = NUM_DIGITS'(1) << idx_q;
    if (digit_dark) begin
      seg_d = '0;
    end
    if (slot_start) begin
      en_d = '0;
    end
    if (blank) begin
      seg_d = '0;
      dot_d = 1'b0;
      en_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      dot_q <= 1'b0;
      en_q  <= '0;
    end else begin
      seg_q <= seg_d;
      dot_q <= dot_d;
      en_q  <= en_d;
    end
  end

  assign seg      = seg_q ^ {SEG_W{ACTIVE_LOW}};
  assign dot      = dot_q ^ ACTIVE_LOW;
  assign digit_en = en_q ^ {NUM_DIGITS{ACTIVE_LOW}};

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Bench for seven_segment_scanner with NUM_DIGITS=4, REFRESH_DIV=4.
//   Two instances share all inputs: one active-high, one ACTIVE_LOW=1.
//   The reference model tracks the number of clock edges since reset and
//   derives slot, phase and digit from it arithmetically.
module tb_seven_segment_scanner;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*N-1:0] value;
  logic [N-1:0]   dots;
  logic           load;
  logic           blank;
  logic [6:0]     seg_h, seg_l;
  logic           dot_h, dot_l;
  logic [N-1:0]   en_h, en_l;

  seven_segment_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) dut_high (
    .clk(clk), .rst(rst), .value(value), .dots(dots), .load(load), .blank(blank),
    .seg(seg_h), .dot(dot_h), .digit_en(en_h)
  );

  seven_segment_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut_low (
    .clk(clk), .rst(rst), .value(value), .dots(dots), .load(load), .blank(blank),
    .seg(seg_l), .dot(dot_l), .digit_en(en_l)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  logic [6:0] dec_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  int         pos;          // edges since reset released
  logic [3:0] sh_val [N];
  logic [N-1:0] sh_dot;

  // scoreboard
  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: predict outputs from the pre-edge model, step the model,
  // then compare both instances shortly after the edge.
  task automatic tick();
    logic [6:0]   e_seg;
    logic         e_dot;
    logic [N-1:0] e_en;
    logic [6:0]   i_seg;
    logic [N-1:0] i_en;
    int           d;
    int           ph;
    bit           all_zero;
    e_seg = '0;
    e_dot = 1'b0;
    e_en  = '0;
    if (!rst && !blank) begin
      d  = (pos / DIV) % N;
      ph = pos % DIV;
      e_seg = dec_tab[sh_val[d]];
      e_dot = sh_dot[d];
      e_en  = (ph == 0) ? '0 : N'(1 << d);
`ifdef SEVEN_SEG_LZB_EN
      all_zero = (d > 0);
      for (int k = d; k < N; k++) if (sh_val[k] != 4'h0) all_zero = 1'b0;
      if (all_zero) e_seg = '0;
`else
      all_zero = 1'b0;
`endif
    end
    @(posedge clk);
    if (rst) begin
      pos = 0;
      for (int k = 0; k < N; k++) sh_val[k] = 4'h0;
      sh_dot = '0;
    end else begin
      pos++;
      if (load) begin
        for (int k = 0; k < N; k++) sh_val[k] = value[4*k +: 4];
        sh_dot = dots;
      end
    end
    #1;
    i_seg = ~e_seg;
    i_en  = ~e_en;
    check("seg",       32'(seg_h), 32'(e_seg));
    check("dot",       32'(dot_h), 32'(e_dot));
    check("digit_en",  32'(en_h),  32'(e_en));
    check("seg_n",     32'(seg_l), 32'(i_seg));
    check("dot_n",     32'(dot_l), 32'(!e_dot));
    check("digit_en_n",32'(en_l),  32'(i_en));
    check("en_onehot0",32'($onehot0(en_h)), 32'd1);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // advance until the next edge happens at scan position target (mod 16)
  task automatic run_to(input int target);
    for (int k = 0; k < 2 * N * DIV && (pos % (N * DIV)) != target; k++) tick();
  endtask

  initial begin
    pos    = 0;
    sh_dot = '0;
    for (int k = 0; k < N; k++) sh_val[k] = 4'h0;
    rst = 1'b1; load = 1'b0; blank = 1'b0; value = '0; dots = '0;

    // reset state
    run(3);
    rst = 1'b0;

    // basic scan of 3A0F with a dot on digit 2, plus wrap over 64 clocks
    value = 16'h3A0F; dots = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    run(64);

    // load coinciding with the slot 1 -> slot 2 advance
    run_to(7);
    value = 16'h5C21; dots = 4'b1001; load = 1'b1;
    tick();
    load = 1'b0;
    run(12);

    // blank for 6 clocks starting mid-slot
    run_to(2);
    blank = 1'b1;
    run(6);
    blank = 1'b0;
    run(20);

    // reset pulsed during slot 2
    run_to(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    value = 16'h3A0F; dots = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    run(20);

    // leading zeros (0008), seen on both polarities
    value = 16'h0008; dots = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    run(20);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 59) == 0);
      load  = ($urandom_range(0, 7) == 0);
      blank = ($urandom_range(0, 11) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
      dots  = 4'($urandom);
      tick();
    end
    rst = 1'b0; load = 1'b0; blank = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
